mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial RAM arbiter between instruction fetch and load/store.
// Round-robin on ties, each access runs to a one-cycle DONE with a success pulse.
module mem_ctrl #(
  parameter logic [31:0] IO_THRESHOLD = 32'h0003_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_flag,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        if_success,
  output logic [31:0] if_data,
  input  logic        lsb_enable,
  input  logic [2:0]  lsb_op_size,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  input  logic        lsb_wr_tag,
  output logic        lsb_success,
  output logic [31:0] lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;

  state_t      state, state_nxt;
  logic        rr_lsb;   // 1 = LSB was served last
  logic        cur_if;
  logic        cur_io;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic [31:0] rd_word;
  logic [2:0]  n;
  logic [2:0]  cnt;
  logic [2:0]  lsb_n;
  logic [1:0]  cap_idx;
  logic [7:0]  wr_byte;
  logic        if_req;
  logic        grant_if;
  logic        grant_lsb;
  logic        grant_io;

  assign if_req   = if_enable && !jump_flag;
  assign grant_io = (lsb_addr >= IO_THRESHOLD);
  assign cap_idx  = cnt[1:0] - 2'd2;
  assign wr_byte  = wdata[{cnt[1:0], 3'b000} +: 8];

  always_comb begin
    case (lsb_op_size)
      3'd2:    lsb_n = 3'd2;
      3'd4:    lsb_n = 3'd4;
      default: lsb_n = 3'd1;
    endcase
  end

  // Byte arriving this edge merged into the partial word.
  always_comb begin
    rd_word = rbuf;
    rd_word[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_lsb = 1'b0;
    case (state)
      IDLE: begin
        if (lsb_enable && (!if_req || !rr_lsb)) begin
          grant_lsb = 1'b1;
          state_nxt = lsb_wr_tag ? LS_WR : LS_RD;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = IF_RD;
        end
      end
      IF_RD:   if (jump_flag) state_nxt = IDLE;
               else if (cnt == n + 3'd1) state_nxt = DONE;
      LS_RD:   if (cnt == n + 3'd1) state_nxt = DONE;
      LS_WR:   if (cnt == n) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_lsb <= 1'b0; cur_if <= 1'b0; cur_io <= 1'b0;
      addr <= '0; wdata <= '0; rbuf <= '0; n <= '0; cnt <= '0;
      mem_a <= '0; mem_dout <= '0; mem_wr <= 1'b0;
      if_success <= 1'b0; lsb_success <= 1'b0;
      if_data <= '0; lsb_rdata <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          mem_a  <= '0;
          mem_wr <= 1'b0;
          if (grant_if) begin
            rr_lsb <= 1'b0; cur_if <= 1'b1; cur_io <= 1'b0;
            addr <= if_addr; n <= 3'd4; cnt <= 3'd1; rbuf <= '0;
            mem_a <= if_addr;
          end else if (grant_lsb) begin
            rr_lsb <= 1'b1; cur_if <= 1'b0; cur_io <= grant_io;
            addr <= lsb_addr; wdata <= lsb_wdata; n <= lsb_n; rbuf <= '0;
            if (lsb_wr_tag && grant_io && io_buffer_full) begin
              cnt <= 3'd0;
            end else begin
              cnt   <= 3'd1;
              mem_a <= lsb_addr;
              if (lsb_wr_tag) begin
                mem_dout <= lsb_wdata[7:0];
                mem_wr   <= 1'b1;
              end
            end
          end
        end
        IF_RD, LS_RD: begin
          if (state == IF_RD && jump_flag) begin
            mem_a <= '0;
          end else begin
            cnt <= cnt + 3'd1;
            if (cnt < n) mem_a <= addr + {29'b0, cnt};
            if (cnt >= 3'd2) rbuf <= rd_word;
            if (cnt == n + 3'd1) begin
              mem_a <= '0;
              if (cur_if) begin
                if_data    <= rd_word;
                if_success <= 1'b1;
              end else begin
                lsb_rdata   <= rd_word;
                lsb_success <= 1'b1;
              end
            end
          end
        end
        LS_WR: begin
          if (cnt == n) begin
            mem_a       <= '0;
            mem_dout    <= '0;
            mem_wr      <= 1'b0;
            lsb_success <= 1'b1;
          end else if (cur_io && io_buffer_full) begin
            mem_wr <= 1'b0;
          end else begin
            mem_a    <= addr + {29'b0, cnt};
            mem_dout <= wr_byte;
            mem_wr   <= 1'b1;
            cnt      <= cnt + 3'd1;
          end
        end
        DONE: begin
          if_success  <= 1'b0;
          lsb_success <= 1'b0;
          mem_a       <= '0;
          mem_wr      <= 1'b0;
        end
        default: begin
          mem_a  <= '0;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM on the bus, shadow memory model, directed corner cases
// followed by randomized fetch/load/store traffic.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy, jump_flag, if_enable, lsb_enable, lsb_wr_tag, io_buffer_full;
  logic [31:0] if_addr, lsb_addr, lsb_wdata, if_data, lsb_rdata, mem_a;
  logic [2:0]  lsb_op_size;
  logic        if_success, lsb_success, mem_wr;
  logic [7:0]  mem_din, mem_dout;

  int checks = 0;
  int errors = 0;
  int both_hi = 0;
  int wr_cycles;
  logic [7:0]  ram     [0:65535];
  logic [7:0]  ref_ram [0:65535];
  logic [39:0] wr_log[$];
  logic [31:0] trace [0:15];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_flag(jump_flag),
    .if_enable(if_enable), .if_addr(if_addr), .if_success(if_success), .if_data(if_data),
    .lsb_enable(lsb_enable), .lsb_op_size(lsb_op_size), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_wr_tag(lsb_wr_tag), .lsb_success(lsb_success),
    .lsb_rdata(lsb_rdata), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM with one cycle of read latency; every written byte is logged.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[15:0]];
    if (mem_wr) begin
      ram[mem_a[15:0]] <= mem_dout;
      wr_log.push_back({mem_a, mem_dout});
    end
  end

  always @(negedge clk) if (if_success && lsb_success) both_hi++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] sz);
    return (sz == 3'd1 || sz == 3'd2 || sz == 3'd4) ? int'(sz) : 1;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int nb);
    logic [31:0] w = '0;
    logic [31:0] t;
    for (int i = 0; i < nb; i++) begin
      t = a + 32'(i);
      w[8*i +: 8] = ref_ram[t[15:0]];
    end
    return w;
  endfunction

  task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
    ram[a[15:0]] = v;
    ref_ram[a[15:0]] = v;
  endtask

  // One request from a single requester; returns read data and cycles to the pulse.
  task automatic txn(input bit is_if, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output int lat);
    bit got = 1'b0;
    wr_log.delete();
    wr_cycles = 0;
    lat = 0;
    if (is_if) begin
      if_enable = 1'b1; if_addr = a;
    end else begin
      lsb_enable = 1'b1; lsb_wr_tag = wr; lsb_op_size = sz; lsb_addr = a; lsb_wdata = wd;
    end
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat <= 16) trace[lat-1] = mem_a;
      if (mem_wr) wr_cycles++;
      got = is_if ? if_success : lsb_success;
    end
    if_enable = 1'b0;
    lsb_enable = 1'b0;
    chk("done", 32'(got), 32'd1);
    rd = is_if ? if_data : lsb_rdata;
    @(posedge clk); #1;
    chk("pulse_width", 32'(is_if ? if_success : lsb_success), 32'd0);
  endtask

  // Both requesters at once; reports which finished first (1 = LSB, 2 = IF).
  task automatic tie(input logic [31:0] ia, input logic [31:0] la, output int first);
    bit idone = 1'b0, ldone = 1'b0;
    int cyc = 0;
    first = 0;
    if_enable = 1'b1; if_addr = ia;
    lsb_enable = 1'b1; lsb_wr_tag = 1'b0; lsb_op_size = 3'd4; lsb_addr = la;
    while (!(idone && ldone) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (if_success) begin
        if (first == 0) first = 2;
        idone = 1'b1; if_enable = 1'b0;
        chk("tie_if_data", if_data, ref_read(ia, 4));
      end
      if (lsb_success) begin
        if (first == 0) first = 1;
        ldone = 1'b1; lsb_enable = 1'b0;
        chk("tie_lsb_data", lsb_rdata, ref_read(la, 4));
      end
    end
    chk("tie_both_done", 32'(idone && ldone), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, a, wd, t;
    logic [2:0]  sz;
    int lat, first, nb, kind, stray;

    for (int i = 0; i < 65536; i++) begin
      t = $urandom;
      ram[i] = t[7:0];
      ref_ram[i] = t[7:0];
    end
    rst = 1'b1; rdy = 1'b1; jump_flag = 1'b0; io_buffer_full = 1'b0;
    if_enable = 1'b0; if_addr = '0; lsb_enable = 1'b0; lsb_wr_tag = 1'b0;
    lsb_op_size = 3'd0; lsb_addr = '0; lsb_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_dout", 32'(mem_dout), 0);
    chk("rst_success", {30'b0, if_success, lsb_success}, 0);
    chk("rst_data", if_data | lsb_rdata, 0);
    rst = 1'b0;

    // Word fetch with known bytes.
    set_byte(32'h100, 8'h13); set_byte(32'h101, 8'h00);
    set_byte(32'h102, 8'h01); set_byte(32'h103, 8'h02);
    txn(1'b1, 1'b0, 3'd4, 32'h100, '0, rd, lat);
    chk("fetch_data", rd, 32'h0201_0013);
    chk("fetch_lat", lat, 6);
    for (int i = 0; i < 4; i++) chk("fetch_addr", trace[i], 32'h100 + 32'(i));

    // Ties right after reset: LSB first, then again on the following tie.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    tie(32'h400, 32'h500, first);
    chk("tie1_first", first, 1);
    tie(32'h600, 32'h700, first);
    chk("tie2_first", first, 1);

    // Halfword store.
    txn(1'b0, 1'b1, 3'd2, 32'h200, 32'hAABB_CCDD, rd, lat);
    chk("sh_lat", lat, 3);
    chk("sh_wr_cycles", wr_cycles, 2);
    chk("sh_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("sh_b0", wr_log[0], {32'h200, 8'hDD});
      chk("sh_b1", wr_log[1], {32'h201, 8'hCC});
    end
    set_byte(32'h200, 8'hDD); set_byte(32'h201, 8'hCC);

    // Byte store into the I/O region with the sink full for three cycles.
    io_buffer_full = 1'b1;
    fork
      txn(1'b0, 1'b1, 3'd1, 32'h0003_0000, 32'h0000_005A, rd, lat);
      begin repeat (3) @(posedge clk); #1; io_buffer_full = 1'b0; end
    join
    chk("io_lat", lat, 5);
    chk("io_wr_cycles", wr_cycles, 1);
    chk("io_nwr", wr_log.size(), 1);
    if (wr_log.size() == 1) chk("io_byte", wr_log[0], {32'h0003_0000, 8'h5A});
    ref_ram[0] = 8'h5A;

    // Flush during a fetch at byte 2; the waiting load proceeds afterwards.
    if_enable = 1'b1; if_addr = 32'h800;
    lsb_enable = 1'b1; lsb_wr_tag = 1'b0; lsb_op_size = 3'd4; lsb_addr = 32'h900;
    repeat (3) @(posedge clk);
    #1;
    chk("jmp_byte2", mem_a, 32'h802);
    jump_flag = 1'b1;
    @(posedge clk); #1;
    chk("jmp_mem_a", mem_a, 0);
    chk("jmp_mem_wr", 32'(mem_wr), 0);
    jump_flag = 1'b0; if_enable = 1'b0;
    stray = 0; lat = 0;
    while (!lsb_success && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (if_success) stray++;
    end
    chk("jmp_no_if", stray, 0);
    chk("jmp_lsb_done", 32'(lsb_success), 1);
    chk("jmp_lsb_data", lsb_rdata, ref_read(32'h900, 4));
    lsb_enable = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a word load.
    lsb_enable = 1'b1; lsb_wr_tag = 1'b0; lsb_op_size = 3'd4; lsb_addr = 32'h1234;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; lsb_enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_a", mem_a, 0);
    chk("mid_rst_wr", 32'(mem_wr), 0);
    chk("mid_rst_rdata", lsb_rdata, 0);
    stray = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (lsb_success || if_success) stray++;
    end
    chk("mid_rst_nopulse", stray, 0);
    txn(1'b0, 1'b0, 3'd4, 32'h1234, '0, rd, lat);
    chk("post_rst_data", rd, ref_read(32'h1234, 4));
    chk("post_rst_lat", lat, 6);

    // Random traffic in a small window so loads revisit stored bytes.
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 2);
      sz   = 3'($urandom_range(0, 7));
      a    = 32'h1000 + 32'($urandom_range(0, 63));
      wd   = $urandom;
      nb   = (kind == 0) ? 4 : nbytes(sz);
      txn(kind == 0, kind == 2, sz, a, wd, rd, lat);
      if (kind == 2) begin
        chk("rnd_st_lat", lat, nb + 1);
        chk("rnd_st_nwr", wr_log.size(), nb);
        for (int i = 0; i < nb && i < wr_log.size(); i++) begin
          chk("rnd_st_addr", wr_log[i][39:8], a + 32'(i));
          chk("rnd_st_byte", 32'(wr_log[i][7:0]), 32'(wd[8*i +: 8]));
        end
        for (int i = 0; i < nb; i++) begin
          t = a + 32'(i);
          ref_ram[t[15:0]] = wd[8*i +: 8];
        end
      end else begin
        chk("rnd_rd_lat", lat, nb + 2);
        chk(kind == 0 ? "rnd_fetch" : "rnd_load", rd, ref_read(a, nb));
      end
    end

    chk("never_both", both_hi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
